n15_run_monitor: RTL and testbench



---
 rtl/n15_mon_pkg.sv | 19 +
 rtl/n15_sat_counter.sv | 21 ++
 rtl/n15_run_monitor.sv | 125 ++++++++++++
 tb/tb_n15_run_monitor.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/n15_mon_pkg.sv
// Shared types and defaults for the N15 end-of-run monitor.
package n15_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE    = 2'b00,
        RES_PASS    = 2'b01,
        RES_FAIL    = 2'b10,
        RES_TIMEOUT = 2'b11
    } result_t;

    localparam logic [31:0] DEFAULT_PASS_SIG = 32'h600D_BAD0;

endpackage

// File: rtl/n15_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module n15_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state is assigned with <= so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/n15_run_monitor.sv
// End-of-run monitor: tracks per-hart halts, retire counts, a hang watchdog
// and a pass/fail signature, reporting a registered result when the run ends.
module n15_run_monitor
    import n15_mon_pkg::*;
#(
    parameter int unsigned      NHARTS    = 1,
    parameter int unsigned      CW        = 32,
    parameter int unsigned      HALT_ALL  = 1,
    parameter int unsigned      WDT_W     = 20,
    parameter logic [WDT_W-1:0] WDT_LIMIT = 20'hF_FFFF,
    parameter logic [31:0]      PASS_SIG  = DEFAULT_PASS_SIG
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NHARTS-1:0]    retire,
    input  logic [NHARTS-1:0]    halt,
    input  logic                 sig_we,
    input  logic [31:0]          sig_wdata,
    output logic                 running,
    output logic                 done,
    output logic [1:0]           result,
    output logic [CW-1:0]        cycles,
    output logic [NHARTS*CW-1:0] instret,
    output logic [NHARTS-1:0]    halted,
    output logic [31:0]          sig
);

    // Timeout fires in the cycle whose increment would bring the watchdog to the limit.
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_LIMIT - WDT_W'(1);

    state_t            state, state_next;
    result_t           result_q, result_next;
    logic [NHARTS-1:0] halted_q, halted_next, live_retire;
    logic [31:0]       sig_q, sig_final;
    logic [WDT_W-1:0]  wdt;
    logic              in_run, enter_run, any_live, complete, timeout;

    assign in_run      = (state == ST_RUN);
    assign enter_run   = start && !in_run;
    assign live_retire = retire & ~halted_q;
    assign any_live    = |live_retire;
    assign halted_next = halted_q | halt;
    assign complete    = (HALT_ALL != 0) ? &halted_next : |halted_next;
    assign timeout     = !any_live && (wdt == WDT_LAST);
    assign sig_final   = sig_we ? sig_wdata : sig_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next  = state;
        result_next = result_q;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next  = ST_RUN;
                    result_next = RES_NONE;
                end
            end
            ST_RUN: begin
                if (complete || timeout) begin
                    state_next = ST_DONE;
                    if (complete) begin
                        result_next = (sig_final == PASS_SIG) ? RES_PASS : RES_FAIL;
                    end else begin
                        result_next = RES_TIMEOUT;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            result_q <= RES_NONE;
            halted_q <= '0;
            sig_q    <= '0;
        end else begin
            state    <= state_next;
            result_q <= result_next;
            if (enter_run) begin
                halted_q <= '0;
                sig_q    <= '0;
            end else if (in_run) begin
                halted_q <= halted_next;
                if (sig_we) sig_q <= sig_wdata;
            end
        end
    end

    n15_sat_counter #(.W(CW)) u_cycles (
        .clk   (clk),
        .rst   (rst),
        .clr   (enter_run),
        .inc   (in_run),
        .count (cycles)
    );

    // A halted hart's retires are ignored both for counting and for feeding the watchdog.
    for (genvar i = 0; i < NHARTS; i++) begin : g_instret
        n15_sat_counter #(.W(CW)) u_instret (
            .clk   (clk),
            .rst   (rst),
            .clr   (enter_run),
            .inc   (in_run && live_retire[i]),
            .count (instret[i*CW +: CW])
        );
    end

    n15_sat_counter #(.W(WDT_W)) u_wdt (
        .clk   (clk),
        .rst   (rst),
        .clr   (enter_run || (in_run && any_live)),
        .inc   (in_run),
        .count (wdt)
    );

    assign running = in_run;
    assign done    = (state == ST_DONE);
    assign result  = result_q;
    assign halted  = halted_q;
    assign sig     = sig_q;

endmodule

// File: tb/tb_n15_run_monitor.sv
// Bench for n15_run_monitor: three configurations checked every cycle against
// a behavioural model, plus hand-computed expectations at scenario ends.
module tb_n15_run_monitor;

    localparam logic [31:0] PASS = 32'h600D_BAD0;
    localparam longint unsigned LIMIT = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // a: 1 hart, all-halt, CW=4
    logic        start_a, we_a, running_a, done_a;
    logic [0:0]  retire_a, halt_a, halted_a;
    logic [31:0] wd_a, sig_a;
    logic [1:0]  result_a;
    logic [3:0]  cycles_a, instret_a;
    // b: 2 harts, all-halt, CW=32
    logic        start_b, we_b, running_b, done_b;
    logic [1:0]  retire_b, halt_b, halted_b, result_b;
    logic [31:0] wd_b, sig_b, cycles_b;
    logic [63:0] instret_b;
    // c: 2 harts, any-halt, CW=32
    logic        start_c, we_c, running_c, done_c;
    logic [1:0]  retire_c, halt_c, halted_c, result_c;
    logic [31:0] wd_c, sig_c, cycles_c;
    logic [63:0] instret_c;

    n15_run_monitor #(.NHARTS(1), .CW(4), .HALT_ALL(1), .WDT_W(20), .WDT_LIMIT(20'd16)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .retire(retire_a), .halt(halt_a),
        .sig_we(we_a), .sig_wdata(wd_a), .running(running_a), .done(done_a),
        .result(result_a), .cycles(cycles_a), .instret(instret_a), .halted(halted_a), .sig(sig_a));

    n15_run_monitor #(.NHARTS(2), .CW(32), .HALT_ALL(1), .WDT_W(20), .WDT_LIMIT(20'd16)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .retire(retire_b), .halt(halt_b),
        .sig_we(we_b), .sig_wdata(wd_b), .running(running_b), .done(done_b),
        .result(result_b), .cycles(cycles_b), .instret(instret_b), .halted(halted_b), .sig(sig_b));

    n15_run_monitor #(.NHARTS(2), .CW(32), .HALT_ALL(0), .WDT_W(20), .WDT_LIMIT(20'd16)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .retire(retire_c), .halt(halt_c),
        .sig_we(we_c), .sig_wdata(wd_c), .running(running_c), .done(done_c),
        .result(result_c), .cycles(cycles_c), .instret(instret_c), .halted(halted_c), .sig(sig_c));

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state per instance: phase 0 idle, 1 run, 2 done.
    int              m_st  [3];
    logic [1:0]      m_res [3];
    longint unsigned m_cyc [3];
    longint unsigned m_ir  [3][2];
    bit              m_hl  [3][2];
    logic [31:0]     m_sig [3];
    longint unsigned m_wdt [3];

    task automatic model_clear(input int u);
        m_res[u] = 2'b00;
        m_cyc[u] = 0;
        m_sig[u] = 32'h0;
        m_wdt[u] = 0;
        for (int h = 0; h < 2; h++) begin
            m_ir[u][h] = 0;
            m_hl[u][h] = 1'b0;
        end
    endtask

    task automatic model_step(input int u, input int nh, input bit all_mode, input int cw,
                              input bit st_in, input logic [1:0] rt, input logic [1:0] hl,
                              input bit we, input logic [31:0] wd);
        longint unsigned maxv;
        bit active, all_h, any_h, complete;
        maxv = (64'd1 << cw) - 1;
        if (rst) begin
            m_st[u] = 0;
            model_clear(u);
        end else if (m_st[u] != 1) begin
            if (st_in) begin
                m_st[u] = 1;
                model_clear(u);
            end
        end else begin
            active = 1'b0;
            for (int h = 0; h < nh; h++) begin
                if (rt[h] && !m_hl[u][h]) begin
                    active = 1'b1;
                    if (m_ir[u][h] < maxv) m_ir[u][h]++;
                end
            end
            if (m_cyc[u] < maxv) m_cyc[u]++;
            for (int h = 0; h < nh; h++) if (hl[h]) m_hl[u][h] = 1'b1;
            if (we) m_sig[u] = wd;
            all_h = 1'b1;
            any_h = 1'b0;
            for (int h = 0; h < nh; h++) begin
                all_h = all_h & m_hl[u][h];
                any_h = any_h | m_hl[u][h];
            end
            complete = all_mode ? all_h : any_h;
            m_wdt[u] = active ? 0 : m_wdt[u] + 1;
            if (complete) begin
                m_st[u]  = 2;
                m_res[u] = (m_sig[u] == PASS) ? 2'b01 : 2'b10;
            end else if (m_wdt[u] >= LIMIT) begin
                m_st[u]  = 2;
                m_res[u] = 2'b11;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 1, 1'b1, 4,  start_a, {1'b0, retire_a}, {1'b0, halt_a}, we_a, wd_a);
        model_step(1, 2, 1'b1, 32, start_b, retire_b, halt_b, we_b, wd_b);
        model_step(2, 2, 1'b0, 32, start_c, retire_c, halt_c, we_c, wd_c);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("a.running", running_a, m_st[0] == 1);
            check("a.done",    done_a,    m_st[0] == 2);
            check("a.result",  result_a,  m_res[0]);
            check("a.cycles",  cycles_a,  m_cyc[0]);
            check("a.instret", instret_a, m_ir[0][0]);
            check("a.halted",  halted_a,  m_hl[0][0]);
            check("a.sig",     sig_a,     m_sig[0]);
            check("b.running", running_b, m_st[1] == 1);
            check("b.done",    done_b,    m_st[1] == 2);
            check("b.result",  result_b,  m_res[1]);
            check("b.cycles",  cycles_b,  m_cyc[1]);
            check("b.instret0", instret_b[31:0],  m_ir[1][0]);
            check("b.instret1", instret_b[63:32], m_ir[1][1]);
            check("b.halted",  halted_b,  {m_hl[1][1], m_hl[1][0]});
            check("b.sig",     sig_b,     m_sig[1]);
            check("c.running", running_c, m_st[2] == 1);
            check("c.done",    done_c,    m_st[2] == 2);
            check("c.result",  result_c,  m_res[2]);
            check("c.cycles",  cycles_c,  m_cyc[2]);
            check("c.instret0", instret_c[31:0],  m_ir[2][0]);
            check("c.instret1", instret_c[63:32], m_ir[2][1]);
            check("c.halted",  halted_c,  {m_hl[2][1], m_hl[2][0]});
            check("c.sig",     sig_c,     m_sig[2]);
        end
    end

    task automatic clear_inputs();
        start_a = 0; retire_a = '0; halt_a = '0; we_a = 0; wd_a = '0;
        start_b = 0; retire_b = '0; halt_b = '0; we_b = 0; wd_b = '0;
        start_c = 0; retire_c = '0; halt_c = '0; we_c = 0; wd_c = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL bench_timeout: got running expected finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        check("lit.reset.running", running_b, 1'b0);
        check("lit.reset.result",  result_b,  2'b00);
        check("lit.reset.cycles",  cycles_b,  32'd0);

        // a: ten retires, signature write, halt with retire on cycle 12 -> pass
        start_a = 1; tick();
        check("lit.a1.running", running_a, 1'b1);
        for (int j = 1; j <= 12; j++) begin
            retire_a = (j <= 10 || j == 12) ? 1'b1 : 1'b0;
            if (j == 11) begin we_a = 1; wd_a = PASS; end
            if (j == 12) halt_a = 1'b1;
            tick();
        end
        check("lit.a1.done",    done_a,    1'b1);
        check("lit.a1.running", running_a, 1'b0);
        check("lit.a1.result",  result_a,  2'b01);
        check("lit.a1.cycles",  cycles_a,  4'd12);
        check("lit.a1.instret", instret_a, 4'd11);
        // frozen in DONE
        for (int j = 0; j < 3; j++) begin
            retire_a = 1; halt_a = 1; we_a = 1; wd_a = 32'h1234_5678;
            tick();
        end
        check("lit.a1.frozen_sig", sig_a, PASS);

        // a: counters saturate at 4'hF
        start_a = 1; tick();
        for (int j = 1; j <= 21; j++) begin
            retire_a = (j <= 20) ? 1'b1 : 1'b0;
            if (j == 21) begin halt_a = 1; we_a = 1; wd_a = PASS; end
            tick();
        end
        check("lit.a2.instret", instret_a, 4'hF);
        check("lit.a2.cycles",  cycles_a,  4'hF);
        check("lit.a2.result",  result_a,  2'b01);

        // b: all-halt, hart0 at 5, hart1 at 9, failing signature
        start_b = 1; tick();
        for (int j = 1; j <= 9; j++) begin
            retire_b = 2'b11;
            halt_b = (j == 5) ? 2'b01 : (j == 9) ? 2'b10 : 2'b00;
            if (j == 7) begin we_b = 1; wd_b = 32'hDEAD_BEEF; end
            tick();
            if (j == 8) check("lit.b1.not_done", done_b, 1'b0);
        end
        check("lit.b1.done",     done_b,           1'b1);
        check("lit.b1.result",   result_b,         2'b10);
        check("lit.b1.halted",   halted_b,         2'b11);
        check("lit.b1.cycles",   cycles_b,         32'd9);
        check("lit.b1.instret0", instret_b[31:0],  32'd5);
        check("lit.b1.instret1", instret_b[63:32], 32'd9);

        // b: pure timeout after 16 idle RUN cycles
        start_b = 1; tick();
        for (int j = 1; j <= 16; j++) begin
            tick();
            if (j == 15) check("lit.b2.running15", running_b, 1'b1);
        end
        check("lit.b2.result", result_b, 2'b11);
        check("lit.b2.cycles", cycles_b, 32'd16);
        check("lit.b2.done",   done_b,   1'b1);

        // b: halt and timeout in the same cycle -> completion wins
        start_b = 1; tick();
        for (int j = 1; j <= 16; j++) begin
            if (j == 16) begin halt_b = 2'b11; we_b = 1; wd_b = PASS; end
            tick();
        end
        check("lit.b3.result", result_b, 2'b01);
        check("lit.b3.cycles", cycles_b, 32'd16);

        // c: any-halt, hart1 halts on cycle 3
        start_c = 1; tick();
        for (int j = 1; j <= 3; j++) begin
            retire_c = (j == 3) ? 2'b11 : 2'b01;
            if (j == 3) halt_c = 2'b10;
            tick();
        end
        check("lit.c1.done",     done_c,           1'b1);
        check("lit.c1.halted",   halted_c,         2'b10);
        check("lit.c1.cycles",   cycles_c,         32'd3);
        check("lit.c1.instret0", instret_c[31:0],  32'd3);
        check("lit.c1.instret1", instret_c[63:32], 32'd1);
        check("lit.c1.result",   result_c,         2'b10);

        // c: a single retire restarts the watchdog
        start_c = 1; tick();
        for (int j = 1; j <= 27; j++) begin
            if (j == 11) retire_c = 2'b01;
            if (j == 27) begin halt_c = 2'b01; we_c = 1; wd_c = PASS; end
            tick();
        end
        check("lit.c2.cycles", cycles_c, 32'd27);
        check("lit.c2.result", result_c, 2'b01);

        // a: reset mid-run beats a simultaneous start
        start_a = 1; tick();
        for (int j = 1; j <= 5; j++) begin
            retire_a = 1;
            if (j == 3) begin we_a = 1; wd_a = 32'hCAFE_F00D; end
            tick();
        end
        rst = 1; start_a = 1; tick();
        rst = 0;
        check("lit.a3.running", running_a, 1'b0);
        check("lit.a3.cycles",  cycles_a,  4'd0);
        check("lit.a3.instret", instret_a, 4'd0);
        check("lit.a3.sig",     sig_a,     32'd0);
        check("lit.a3.result",  result_a,  2'b00);

        // a: clean rerun; start during RUN is ignored
        start_a = 1; tick();
        for (int j = 1; j <= 4; j++) begin
            retire_a = (j <= 3) ? 1'b1 : 1'b0;
            if (j == 2) start_a = 1;
            if (j == 4) halt_a = 1;
            tick();
        end
        check("lit.a4.cycles",  cycles_a,  4'd4);
        check("lit.a4.instret", instret_a, 4'd3);
        check("lit.a4.result",  result_a,  2'b10);

        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
